// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, index type and read-port state encoding for regfile_mp.
package regfile_pkg;
   localparam int REG_NUM_DEF = 32;
   localparam int SP_IDX_DEF = 2;
   localparam logic [31:0] SP_INIT_DEF = 32'h0001_0000;
   typedef logic [$clog2(REG_NUM_DEF)-1:0] idx_t;
   typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one read port; stalls on busy targets, registered ack/data.
// fwd is the write strobe when REGFILE_BYPASS_EN forwarding is built in, else tied low.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int REG_SZ = 32,
   parameter int REG_NUM = REG_NUM_DEF,
   parameter int IDX_W = $clog2(REG_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [IDX_W-1:0]  idx,
   input  logic [REG_SZ-1:0] regs [REG_NUM],
   input  logic [REG_NUM-1:0] busy,
   input  logic              fwd,
   input  logic [IDX_W-1:0]  w_idx,
   input  logic [REG_SZ-1:0] din,
   output logic              ack,
   output logic [REG_SZ-1:0] data
);
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [DEPTH-1:0] OK = DEPTH'({REG_NUM{1'b1}});
   rd_state_t st;
   logic [IDX_W-1:0] cap, tgt;
   logic go, zero, hit, ready;
   logic [REG_SZ-1:0] val;
   // indices past REG_NUM read as zero and never stall
   always_comb begin
      tgt = st == RD_WAIT ? cap : idx;
      go = st == RD_WAIT || req;
      zero = tgt == '0 || !OK[tgt];
      hit = fwd && w_idx == tgt;
      ready = zero || hit || !busy[tgt];
      val = zero ? '0 : hit ? din : regs[tgt];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= RD_IDLE;
         cap <= '0;
         ack <= 1'b0;
         data <= '0;
      end else begin
         ack <= go && ready;
         if (go && ready) data <= val;
         st <= go && !ready ? RD_WAIT : RD_IDLE;
         if (st == RD_IDLE) cap <= idx;
      end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward write data to same-cycle and waiting reads.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int REG_SZ = 32,
   parameter int REG_NUM = REG_NUM_DEF,
   parameter int IDX_W = $clog2(REG_NUM),
   parameter int NRD = 2,
   parameter int SP_IDX = SP_IDX_DEF,
   parameter logic [REG_SZ-1:0] SP_INIT = REG_SZ'(SP_INIT_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD-1:0]        rd_req,
   input  logic [NRD*IDX_W-1:0]  rd_idx,
   output logic [NRD-1:0]        rd_ack,
   output logic [NRD*REG_SZ-1:0] rd_data,
   input  logic                  we,
   input  logic [IDX_W-1:0]      w_idx,
   input  logic [REG_SZ-1:0]     din,
   output logic                  wack,
   input  logic                  rsv_en,
   input  logic [IDX_W-1:0]      rsv_idx,
   output logic [REG_NUM-1:0]    busy
);
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [DEPTH-1:0] OK = DEPTH'({REG_NUM{1'b1}});
   logic [REG_SZ-1:0] regs [REG_NUM];
   logic fwd;
`ifdef REGFILE_BYPASS_EN
   assign fwd = we;
`else
   assign fwd = 1'b0;
`endif
   // reserve is applied after the write clear so a new producer wins
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) regs[i] <= i == SP_IDX ? SP_INIT : '0;
         busy <= '0;
         wack <= 1'b0;
      end else begin
         wack <= we;
         if (we && OK[w_idx] && w_idx != '0) regs[w_idx] <= din;
         if (we && OK[w_idx]) busy[w_idx] <= 1'b0;
         if (rsv_en && OK[rsv_idx] && rsv_idx != '0) busy[rsv_idx] <= 1'b1;
      end
   for (genvar p = 0; p < NRD; p++) begin : g_rd
      regfile_rd_port #(.REG_SZ(REG_SZ), .REG_NUM(REG_NUM), .IDX_W(IDX_W)) u_port (
         .clk(clk),
         .rst(rst),
         .req(rd_req[p]),
         .idx(rd_idx[p*IDX_W +: IDX_W]),
         .regs(regs),
         .busy(busy),
         .fwd(fwd),
         .w_idx(w_idx),
         .din(din),
         .ack(rd_ack[p]),
         .data(rd_data[p*REG_SZ +: REG_SZ])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed scenarios plus randomized traffic against a register-file reference model.
module tb_regfile_mp;
   import regfile_pkg::*;
   localparam int NRD = 2;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1;
   logic [NRD-1:0] rd_req = '0, rd_ack;
   logic [NRD*5-1:0] rd_idx = '0;
   logic [NRD*32-1:0] rd_data;
   logic we = 1'b0, wack, rsv_en = 1'b0;
   idx_t w_idx = '0, rsv_idx = '0;
   logic [31:0] din = '0, busy;
   int checks = 0, errors = 0;
   logic [31:0] m_reg [32];
   logic [31:0] m_busy;
   bit m_wait [NRD];
   int m_pend [NRD];
   logic [NRD-1:0] e_ack;
   logic [NRD*32-1:0] e_data;
   logic e_wack;

   regfile_mp dut (
      .clk(clk), .rst(rst), .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
      .rd_data(rd_data), .we(we), .w_idx(w_idx), .din(din), .wack(wack),
      .rsv_en(rsv_en), .rsv_idx(rsv_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_reg[i] = (i == 2) ? 32'h0001_0000 : 32'h0;
      m_busy = '0;
      for (int p = 0; p < NRD; p++) m_wait[p] = 1'b0;
      e_ack = '0;
      e_data = '0;
      e_wack = 1'b0;
   endtask

   task automatic idle();
      rd_req = '0; we = 1'b0; rsv_en = 1'b0;
   endtask

   // Apply current inputs to the model, then advance one clock.
   task automatic tick();
      for (int p = 0; p < NRD; p++) begin
         int t;
         bit go, done;
         logic [31:0] v;
         t = m_wait[p] ? m_pend[p] : int'(rd_idx[p*5 +: 5]);
         go = m_wait[p] || rd_req[p];
         done = 1'b0;
         v = '0;
         e_ack[p] = 1'b0;
         if (go) begin
            if (t == 0) done = 1'b1;
            else if (BYP && we && int'(w_idx) == t) begin done = 1'b1; v = din; end
            else if (!m_busy[t]) begin done = 1'b1; v = m_reg[t]; end
            else begin m_wait[p] = 1'b1; m_pend[p] = t; end
         end
         if (done) begin
            e_ack[p] = 1'b1;
            e_data[p*32 +: 32] = v;
            m_wait[p] = 1'b0;
         end
      end
      e_wack = we;
      if (we) begin
         if (w_idx != 0) m_reg[w_idx] = din;
         m_busy[w_idx] = 1'b0;
      end
      if (rsv_en && rsv_idx != 0) m_busy[rsv_idx] = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 32'h0 || rd_ack !== 2'b00 || wack !== 1'b0 || rd_data !== '0) begin
         errors++;
         $display("FAIL reset_state busy=%h ack=%b wack=%b data=%h expected all zero", busy, rd_ack, wack, rd_data);
      end
      rst = 1'b0;
      model_reset();
      rd_req = 2'b11;
      rd_idx = {5'd0, 5'd2};
      tick();
      idle();
      checks++;
      if (rd_ack !== 2'b11 || rd_data !== {32'h0, 32'h0001_0000}) begin
         errors++;
         $display("FAIL reset_read ack=%b data=%h expected 11 %h", rd_ack, rd_data, {32'h0, 32'h0001_0000});
      end
      tick();
      checks++;
      if (rd_ack !== 2'b00) begin
         errors++;
         $display("FAIL reset_read_pulse ack=%b expected 00", rd_ack);
      end
   endtask

   task automatic test_write_read();
      we = 1'b1; w_idx = 5'd5; din = 32'hDEAD_BEEF;
      tick();
      idle();
      checks++;
      if (wack !== 1'b1) begin
         errors++;
         $display("FAIL write_wack got %b expected 1", wack);
      end
      rd_req = 2'b01; rd_idx = {5'd0, 5'd5};
      tick();
      idle();
      checks++;
      if (wack !== 1'b0 || rd_ack !== 2'b01 || rd_data[31:0] !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL write_read wack=%b ack=%b data=%h expected 0 01 deadbeef", wack, rd_ack, rd_data[31:0]);
      end
   endtask

   task automatic test_stall();
      rsv_en = 1'b1; rsv_idx = 5'd7;
      tick();
      idle();
      checks++;
      if (busy[7] !== 1'b1) begin
         errors++;
         $display("FAIL stall_busy got %b expected 1", busy[7]);
      end
      rd_req = 2'b01; rd_idx = {5'd0, 5'd7};
      for (int c = 0; c < 3; c++) begin
         tick();
         idle();
         checks++;
         if (rd_ack !== 2'b00) begin
            errors++;
            $display("FAIL stall_wait cycle %0d ack=%b expected 00", c, rd_ack);
         end
      end
      we = 1'b1; w_idx = 5'd7; din = 32'h0000_1234;
      tick();
      idle();
      if (!BYP) begin
         checks++;
         if (rd_ack !== 2'b00) begin
            errors++;
            $display("FAIL stall_early ack=%b expected 00", rd_ack);
         end
         tick();
      end
      checks++;
      if (rd_ack !== 2'b01 || rd_data[31:0] !== 32'h0000_1234 || busy[7] !== 1'b0) begin
         errors++;
         $display("FAIL stall_done ack=%b data=%h busy7=%b expected 01 00001234 0", rd_ack, rd_data[31:0], busy[7]);
      end
      tick();
      checks++;
      if (rd_ack !== 2'b00) begin
         errors++;
         $display("FAIL stall_pulse ack=%b expected 00", rd_ack);
      end
   endtask

   task automatic test_rsv_write_same();
      rsv_en = 1'b1; rsv_idx = 5'd9; we = 1'b1; w_idx = 5'd9; din = 32'h0000_AAAA;
      tick();
      idle();
      checks++;
      if (busy[9] !== 1'b1 || wack !== 1'b1) begin
         errors++;
         $display("FAIL rsv_wins busy9=%b wack=%b expected 1 1", busy[9], wack);
      end
      rd_req = 2'b10; rd_idx = {5'd9, 5'd0};
      for (int c = 0; c < 3; c++) begin
         tick();
         idle();
         checks++;
         if (rd_ack !== 2'b00) begin
            errors++;
            $display("FAIL rsv_stall cycle %0d ack=%b expected 00", c, rd_ack);
         end
      end
      we = 1'b1; w_idx = 5'd9; din = 32'h0000_5555;
      tick();
      idle();
      if (!BYP) tick();
      checks++;
      if (rd_ack !== 2'b10 || rd_data[63:32] !== 32'h0000_5555) begin
         errors++;
         $display("FAIL rsv_done ack=%b data=%h expected 10 00005555", rd_ack, rd_data[63:32]);
      end
      tick();
   endtask

   task automatic test_zero();
      we = 1'b1; w_idx = 5'd0; din = 32'h0000_FFFF; rsv_en = 1'b1; rsv_idx = 5'd0;
      tick();
      idle();
      checks++;
      if (wack !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL zero_write wack=%b busy0=%b expected 1 0", wack, busy[0]);
      end
      rd_req = 2'b11; rd_idx = {5'd0, 5'd0};
      tick();
      idle();
      checks++;
      if (rd_ack !== 2'b11 || rd_data !== '0 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL zero_read ack=%b data=%h busy0=%b expected 11 0 0", rd_ack, rd_data, busy[0]);
      end
   endtask

   task automatic test_back_to_back();
      rd_req = 2'b01;
      for (int c = 0; c < 4; c++) begin
         rd_idx = {5'd0, (c == 0) ? 5'd5 : (c == 1) ? 5'd2 : (c == 2) ? 5'd7 : 5'd9};
         tick();
         checks++;
         if (rd_ack !== 2'b01 || rd_data[31:0] !== e_data[31:0]) begin
            errors++;
            $display("FAIL back_to_back cycle %0d ack=%b data=%h expected 01 %h", c, rd_ack, rd_data[31:0], e_data[31:0]);
         end
      end
      idle();
   endtask

   task automatic test_rst_wait();
      we = 1'b1; w_idx = 5'd4; din = 32'h0000_0044; rsv_en = 1'b1; rsv_idx = 5'd4;
      tick();
      idle();
      rd_req = 2'b10; rd_idx = {5'd4, 5'd0};
      tick();
      idle();
      checks++;
      if (rd_ack !== 2'b00) begin
         errors++;
         $display("FAIL rst_wait_pre ack=%b expected 00", rd_ack);
      end
      rst = 1'b1;
      #2;
      checks++;
      if (rd_ack !== 2'b00 || busy !== 32'h0) begin
         errors++;
         $display("FAIL rst_async ack=%b busy=%h expected 00 0", rd_ack, busy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      tick();
      checks++;
      if (rd_ack !== 2'b00) begin
         errors++;
         $display("FAIL rst_no_ack ack=%b expected 00", rd_ack);
      end
      rd_req = 2'b10; rd_idx = {5'd4, 5'd0};
      tick();
      idle();
      checks++;
      if (rd_ack !== 2'b10 || rd_data[63:32] !== 32'h0) begin
         errors++;
         $display("FAIL rst_reg4 ack=%b data=%h expected 10 0", rd_ack, rd_data[63:32]);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         rd_req = 2'($urandom_range(0, 3));
         rd_idx = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         we = ($urandom % 3) == 0;
         w_idx = 5'($urandom_range(0, 7));
         din = $urandom;
         rsv_en = ($urandom % 5) == 0;
         rsv_idx = 5'($urandom_range(0, 7));
         if (rsv_en && we && rsv_idx == w_idx) rsv_en = 1'b0;
         tick();
         checks++;
         if (rd_ack !== e_ack || rd_data !== e_data) begin
            errors++;
            $display("FAIL rand_read cycle %0d ack=%b data=%h expected %b %h", c, rd_ack, rd_data, e_ack, e_data);
         end
         checks++;
         if (wack !== e_wack || busy !== m_busy) begin
            errors++;
            $display("FAIL rand_state cycle %0d wack=%b busy=%h expected %b %h", c, wack, busy, e_wack, m_busy);
         end
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write_read();
      test_stall();
      test_rsv_write_same();
      test_zero();
      test_back_to_back();
      test_rst_wait();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
